// File: rtl/uart_bus_bridge.sv
// Serial-to-bus initiator: 8N1 command frames in on rx_pin, one 32-bit bus read
// or write, response frame out on tx_pin.
module uart_bus_bridge #(
    parameter int unsigned CLK_DIV     = 434,
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_gnt_i,
    output logic        busy_o
);
    localparam int unsigned CW = 16;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP} state_t;

    // ---------------- RX byte engine ----------------
    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     rx_state, rx_state_d;
    logic [CW-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]    rx_bit, rx_bit_d;
    logic [7:0]    rx_shift, rx_shift_d;
    logic          byte_valid_c, frame_err_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= rx_pin;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
        end
    end

    // Mid-bit sampling: half a period after the start edge, then every CLK_DIV.
    always_comb begin
        rx_state_d   = rx_state;
        rx_cnt_d     = rx_cnt + 1'b1;
        rx_bit_d     = rx_bit;
        rx_shift_d   = rx_shift;
        byte_valid_c = 1'b0;
        frame_err_c  = 1'b0;
        unique case (rx_state)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_sync) rx_state_d = R_START;
            end
            R_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync, rx_shift[7:1]};
                    rx_bit_d   = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_state_d   = R_IDLE;
                    byte_valid_c = rx_sync;
                    frame_err_c  = !rx_sync;
                end
            end
        endcase
    end

    // ---------------- TX byte engine ----------------
    logic          tx_active, tx_active_d;
    logic [3:0]    tx_bits, tx_bits_d;
    logic [CW-1:0] tx_cnt, tx_cnt_d;
    logic [8:0]    tx_shift, tx_shift_d;
    logic          tx_pin_d;
    logic          tx_done_c, tx_free_c, tx_start_c;
    logic [7:0]    tx_byte_c;

    assign tx_done_c = tx_active && (tx_bits == 4'd0) && (tx_cnt == DIV_LAST);
    assign tx_free_c = !tx_active || tx_done_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_active <= 1'b0;
            tx_bits   <= '0;
            tx_cnt    <= '0;
            tx_shift  <= '1;
            tx_pin    <= 1'b1;
        end else begin
            tx_active <= tx_active_d;
            tx_bits   <= tx_bits_d;
            tx_cnt    <= tx_cnt_d;
            tx_shift  <= tx_shift_d;
            tx_pin    <= tx_pin_d;
        end
    end

    // A new byte may load in the final stop-bit cycle, giving back-to-back frames.
    always_comb begin
        tx_active_d = tx_active;
        tx_bits_d   = tx_bits;
        tx_cnt_d    = tx_active ? tx_cnt + 1'b1 : '0;
        tx_shift_d  = tx_shift;
        tx_pin_d    = tx_pin;
        if (tx_start_c) begin
            tx_active_d = 1'b1;
            tx_bits_d   = 4'd9;
            tx_cnt_d    = '0;
            tx_shift_d  = {1'b1, tx_byte_c};
            tx_pin_d    = 1'b0;
        end else if (tx_active && tx_cnt == DIV_LAST) begin
            tx_cnt_d = '0;
            if (tx_bits == 4'd0) begin
                tx_active_d = 1'b0;
                tx_pin_d    = 1'b1;
            end else begin
                tx_pin_d   = tx_shift[0];
                tx_shift_d = {1'b1, tx_shift[8:1]};
                tx_bits_d  = tx_bits - 1'b1;
            end
        end
    end

    // ---------------- Frame FSM ----------------
    state_t        state, state_d;
    logic          cmd_we, cmd_we_d;
    logic [1:0]    byte_idx, byte_idx_d;
    logic [TW-1:0] tmo_cnt, tmo_cnt_d;
    logic [31:0]   resp, resp_d;
    logic [2:0]    resp_left, resp_left_d;
    logic          mem_req_d, mem_we_d, busy_d;
    logic [31:0]   addr_d, wdata_d;
    logic [3:0]    sel_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cmd_we     <= 1'b0;
            byte_idx   <= '0;
            tmo_cnt    <= '0;
            resp       <= '0;
            resp_left  <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_sel_o  <= '0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_d;
            cmd_we     <= cmd_we_d;
            byte_idx   <= byte_idx_d;
            tmo_cnt    <= tmo_cnt_d;
            resp       <= resp_d;
            resp_left  <= resp_left_d;
            mem_req_o  <= mem_req_d;
            mem_we_o   <= mem_we_d;
            mem_addr_o <= addr_d;
            mem_data_o <= wdata_d;
            mem_sel_o  <= sel_d;
            busy_o     <= busy_d;
        end
    end

    always_comb begin
        state_d     = state;
        cmd_we_d    = cmd_we;
        byte_idx_d  = byte_idx;
        tmo_cnt_d   = '0;
        resp_d      = resp;
        resp_left_d = resp_left;
        mem_req_d   = mem_req_o;
        mem_we_d    = mem_we_o;
        addr_d      = mem_addr_o;
        wdata_d     = mem_data_o;
        sel_d       = mem_sel_o;
        busy_d      = busy_o;
        tx_start_c  = 1'b0;
        tx_byte_c   = resp[7:0];
        unique case (state)
            S_IDLE: begin
                byte_idx_d = '0;
                if (byte_valid_c) begin
                    busy_d = 1'b1;
                    if (rx_shift == CMD_W || rx_shift == CMD_R) begin
                        cmd_we_d = (rx_shift == CMD_W);
                        state_d  = S_ADDR;
                    end else begin
                        resp_d      = {24'h0, NAK};
                        resp_left_d = 3'd1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ADDR, S_WDATA: begin
                tmo_cnt_d = tmo_cnt + 1'b1;
                if (frame_err_c) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (byte_valid_c) begin
                    tmo_cnt_d  = '0;
                    byte_idx_d = byte_idx + 1'b1;
                    if (state == S_ADDR) addr_d[8*byte_idx +: 8]  = rx_shift;
                    else                 wdata_d[8*byte_idx +: 8] = rx_shift;
                    if (byte_idx == 2'd3)
                        state_d = (state == S_WDATA || !cmd_we) ? S_BUS : S_WDATA;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_BUS: begin
                if (!mem_req_o) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = cmd_we;
                    sel_d     = 4'hF;
                end else if (mem_gnt_i) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    sel_d       = 4'h0;
                    resp_d      = cmd_we ? {24'h0, ACK} : mem_data_i;
                    resp_left_d = cmd_we ? 3'd1 : 3'd4;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_free_c && resp_left != 3'd0) begin
                    tx_start_c  = 1'b1;
                    resp_d      = {8'h0, resp[31:8]};
                    resp_left_d = resp_left - 1'b1;
                end else if (tx_done_c) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: frame-level reference model (expected bus accesses
// and response bytes as queues) checked by a per-cycle monitor.
module tb_uart_bus_bridge;
    localparam int unsigned CLK_DIV     = 16;
    localparam int unsigned TIMEOUT_CYC = 2000;
    localparam int          BYTE_CYC    = 10 * CLK_DIV;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;
    typedef struct { logic [7:0] b; bit b2b; } txb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_pin = 1'b1;
    logic        tx_pin;
    logic        mem_req_o, mem_we_o, busy_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_i = '0;
    logic        mem_gnt_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    bus_t       exp_bus[$];
    txb_t       exp_tx[$];
    logic [7:0] txlog[$];

    logic        snap_we;
    logic [31:0] snap_addr, snap_data;

    uart_bus_bridge #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .rx_pin(rx_pin), .tx_pin(tx_pin),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o), .mem_data_i(mem_data_i),
        .mem_gnt_i(mem_gnt_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %h where nothing was expected (t=%0t)", name, act, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level monitor: bus requests and decoded TX bytes against the model queues.
    int         cyc = 0, dec_t0 = 0, last_t0 = 0, off = 0, k = 0;
    bit         dec_on = 1'b0, prev_req = 1'b0;
    logic [7:0] dec_byte = '0;
    logic       held_we;
    logic [31:0] held_addr, held_data;
    bus_t       cur;
    txb_t       et;

    always @(negedge clk) begin
        cyc++;
        if (mem_req_o === 1'b1) begin
            check("busy_in_req", 32'(busy_o), 32'd1);
            check("req_sel", 32'(mem_sel_o), 32'hF);
            if (!prev_req) begin
                if (exp_bus.size() == 0) fail("unexpected_request", mem_addr_o);
                else begin
                    cur = exp_bus.pop_front();
                    check("req_we", 32'(mem_we_o), 32'(cur.we));
                    check("req_addr", mem_addr_o, cur.addr);
                    if (cur.we) check("req_wdata", mem_data_o, cur.data);
                end
            end else begin
                check("hold_we", 32'(mem_we_o), 32'(held_we));
                check("hold_addr", mem_addr_o, held_addr);
                check("hold_data", mem_data_o, held_data);
            end
            held_we   = mem_we_o;
            held_addr = mem_addr_o;
            held_data = mem_data_o;
        end
        prev_req = (mem_req_o === 1'b1);

        if (dec_on) begin
            off = cyc - dec_t0;
            if (off >= int'(CLK_DIV / 2) && (off - int'(CLK_DIV / 2)) % int'(CLK_DIV) == 0) begin
                k = (off - int'(CLK_DIV / 2)) / int'(CLK_DIV);
                if (k == 0) check("tx_start_bit", 32'(tx_pin), 32'd0);
                else if (k <= 8) dec_byte[k-1] = tx_pin;
                else begin
                    check("tx_stop_bit", 32'(tx_pin), 32'd1);
                    txlog.push_back(dec_byte);
                    if (exp_tx.size() == 0) fail("unexpected_tx_byte", 32'(dec_byte));
                    else begin
                        et = exp_tx.pop_front();
                        check("tx_byte", 32'(dec_byte), 32'(et.b));
                        if (et.b2b) check("tx_b2b_spacing", 32'(dec_t0 - last_t0), 32'(BYTE_CYC));
                    end
                    last_t0 = dec_t0;
                    dec_on  = 1'b0;
                end
            end
        end else if (tx_pin === 1'b0) begin
            dec_on = 1'b1;
            dec_t0 = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_pin = 1'b0;
        repeat (CLK_DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (CLK_DIV) tick();
        end
        rx_pin = stop_bit;
        repeat (CLK_DIV) tick();
        rx_pin = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (mem_req_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail("req_never_raised", 32'(mem_req_o));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < int'(60 * CLK_DIV); i++) begin
            if (busy_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail("busy_never_fell", 32'(busy_o));
        repeat (2 * CLK_DIV) tick();
        check("tx_idle_high", 32'(tx_pin), 32'd1);
        check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        exp_tx.delete();
        exp_bus.delete();
    endtask

    // Model: derive the expected bus access and response bytes from the command.
    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int gnt_dly, input int max_gap);
        logic [7:0] bytes[$];
        bit ok;
        bit is_w = (cmd == 8'h57);
        bit is_r = (cmd == 8'h52);
        bytes.push_back(cmd);
        if (is_w || is_r)
            for (int i = 0; i < 4; i++) bytes.push_back(8'((addr >> (8 * i)) & 32'hFF));
        if (is_w)
            for (int i = 0; i < 4; i++) bytes.push_back(8'((wdata >> (8 * i)) & 32'hFF));
        if (is_w) begin
            exp_bus.push_back('{we: 1'b1, addr: addr, data: wdata});
            exp_tx.push_back('{b: 8'h06, b2b: 1'b0});
        end else if (is_r) begin
            exp_bus.push_back('{we: 1'b0, addr: addr, data: 32'h0});
            for (int i = 0; i < 4; i++)
                exp_tx.push_back('{b: 8'((rdata >> (8 * i)) & 32'hFF), b2b: (i != 0)});
        end else begin
            exp_tx.push_back('{b: 8'h15, b2b: 1'b0});
        end
        foreach (bytes[i]) begin
            send_byte(bytes[i], 1'b1);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        end
        if (is_w || is_r) begin
            wait_req(ok);
            if (ok) begin
                snap_we   = mem_we_o;
                snap_addr = mem_addr_o;
                snap_data = mem_data_o;
                repeat (gnt_dly) tick();
                mem_gnt_i  = 1'b1;
                mem_data_i = rdata;
                tick();
                mem_gnt_i  = 1'b0;
                mem_data_i = $urandom;
                check("req_drop_after_gnt", 32'(mem_req_o), 32'd0);
            end
        end
        wait_idle();
    endtask

    initial begin
        logic [7:0]  c;
        logic [31:0] a;
        bit          ok;
        rst = 1'b0;
        repeat (5) tick();
        check("rst_tx_pin", 32'(tx_pin), 32'd1);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_data", mem_data_o, 32'd0);
        check("rst_sel", 32'(mem_sel_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b1;
        repeat (5) tick();

        // Directed write 57 00 10 00 00 EF BE AD DE, grant after 3 cycles.
        txlog.delete();
        run_frame(8'h57, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 3, 0);
        check("dir_wr_we", 32'(snap_we), 32'd1);
        check("dir_wr_addr", snap_addr, 32'h0000_1000);
        check("dir_wr_data", snap_data, 32'hDEAD_BEEF);
        check("dir_wr_tx_count", 32'(txlog.size()), 32'd1);
        if (txlog.size() == 1) check("dir_wr_ack", 32'(txlog[0]), 32'h06);
        check("dir_wr_busy_low", 32'(busy_o), 32'd0);

        // Directed read 52 04 00 00 20 returning 0x12345678.
        txlog.delete();
        run_frame(8'h52, 32'h2000_0004, 32'h0, 32'h1234_5678, 2, 0);
        check("dir_rd_we", 32'(snap_we), 32'd0);
        check("dir_rd_addr", snap_addr, 32'h2000_0004);
        check("dir_rd_tx_count", 32'(txlog.size()), 32'd4);
        if (txlog.size() == 4)
            check("dir_rd_bytes", {txlog[3], txlog[2], txlog[1], txlog[0]}, 32'h1234_5678);

        // Invalid command.
        txlog.delete();
        run_frame(8'h41, 32'h0, 32'h0, 32'h0, 0, 0);
        check("nak_tx_count", 32'(txlog.size()), 32'd1);
        if (txlog.size() == 1) check("nak_byte", 32'(txlog[0]), 32'h15);

        // Short glitch on rx_pin: no byte, stays idle.
        txlog.delete();
        rx_pin = 1'b0;
        repeat (CLK_DIV / 4) tick();
        rx_pin = 1'b1;
        repeat (3 * BYTE_CYC) tick();
        check("glitch_busy", 32'(busy_o), 32'd0);
        check("glitch_no_tx", 32'(txlog.size()), 32'd0);

        // Framing error on a lone command byte, then mid-frame.
        send_byte(8'h52, 1'b0);
        repeat (3 * BYTE_CYC) tick();
        check("ferr_idle_busy", 32'(busy_o), 32'd0);
        send_byte(8'h52, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (3 * BYTE_CYC) tick();
        check("ferr_frame_busy", 32'(busy_o), 32'd0);
        check("ferr_no_tx", 32'(txlog.size()), 32'd0);

        // Inter-byte timeout, then a full read must still work.
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (TIMEOUT_CYC + 10) tick();
        check("tmo_busy", 32'(busy_o), 32'd0);
        check("tmo_no_tx", 32'(txlog.size()), 32'd0);
        run_frame(8'h52, $urandom, 32'h0, $urandom, 1, 0);

        // Randomised frames.
        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    c = 8'h57;
                2, 3:    c = 8'h52;
                default: begin
                    c = 8'($urandom_range(0, 255));
                    if (c == 8'h57 || c == 8'h52) c = 8'h00;
                end
            endcase
            run_frame(c, $urandom, $urandom, $urandom, int'($urandom_range(0, 5)), 20);
        end

        // Reset while the bus request is pending.
        txlog.delete();
        a = $urandom;
        exp_bus.push_back('{we: 1'b1, addr: a, data: 32'hCAFE_F00D});
        send_byte(8'h57, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'((a >> (8 * i)) & 32'hFF), 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'((32'hCAFE_F00D >> (8 * i)) & 32'hFF), 1'b1);
        wait_req(ok);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check("rst_bus_req", 32'(mem_req_o), 32'd0);
        check("rst_bus_tx", 32'(tx_pin), 32'd1);
        check("rst_bus_busy", 32'(busy_o), 32'd0);
        rst = 1'b1;
        repeat (3 * BYTE_CYC) tick();
        check("rst_bus_no_tx", 32'(txlog.size()), 32'd0);
        check("rst_bus_idle", 32'(busy_o), 32'd0);
        check("rst_bus_queue", 32'(exp_bus.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Serial-to-bus initiator. It is the host-side counterpart of the memory-mapped UART peripheral: it receives 8N1 command frames on a serial pin and issues single 32-bit bus reads or writes.
- It then returns a response frame on its own TX pin.
- Sits between an external debug/download link and the system bus arbiter, as a bus master.

Parameters:
- CLK_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 16..65535.
- TIMEOUT_CYC, 500000, idle cycles allowed between bytes of one frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- rx_pin  in  1  serial input, asynchronous to clk
- tx_pin  out  1  serial output, idle high
- mem_req_o  out  1  bus request, held until granted
- mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o
- mem_addr_o  out  32  bus address
- mem_data_o  out  32  write data
- mem_sel_o  out  4  byte enables, always 4'hF while mem_req_o
- mem_data_i  in  32  read data, valid in the mem_gnt_i cycle
- mem_gnt_i  in  1  grant/complete, one-cycle pulse
- busy_o  out  1  high from first command byte accepted until last response stop bit ends

Behaviour:
- Reset (rst==0 at posedge): tx_pin=1, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, mem_sel_o=0, busy_o=0. All FSMs return to idle, including mid-frame or mid-transaction; a pending request is dropped.

RX byte engine:
- rx_pin passes through a 2-flop synchronizer; the falling-edge detector runs on the synchronized signal.
- Start detection: in idle, a falling edge starts a half-period count (CLK_DIV/2, integer divide). At that point the synchronized input is resampled:
  - if high, false start; return to idle with no byte.
  - if low, take 8 data samples, one every CLK_DIV cycles, LSB first.
  - then sample the stop bit one period later.
- Stop bit = 0 is a framing error: the byte is discarded and the current command frame is aborted (no response).
- A valid byte produces a one-cycle internal byte_valid pulse in the cycle of the stop sample.

Frame FSM:
- States: S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP.
- S_IDLE: on a byte of 0x57 ('W') or 0x52 ('R'), latch the command and go to S_ADDR with byte count 0. On any other byte, queue a NAK 0x15 and go to S_RESP.
- S_ADDR: collect 4 bytes little-endian into the address; the first byte goes to bits [7:0]. After the 4th byte: 'W' goes to S_WDATA, 'R' goes to S_BUS.
- S_WDATA: collect 4 bytes little-endian into the write data, then go to S_BUS.
- Timeout: in S_ADDR and S_WDATA, a counter is cleared on every byte_valid. At TIMEOUT_CYC the FSM returns to S_IDLE with no response and no bus access.
- S_BUS: assert mem_req_o the cycle after entry, with mem_we_o, mem_addr_o, mem_data_o and mem_sel_o=4'hF held stable until mem_gnt_i==1.
  - In the grant cycle, capture mem_data_i (reads only).
  - mem_req_o deasserts the next cycle, and the FSM goes to S_RESP.
  - There is no bus timeout.
- S_RESP: response bytes are:
  - write: 0x06 (ACK)
  - read: the 4 captured data bytes, LSB byte first
  - invalid command: 0x15 (NAK)
  - After the last stop bit ends, go to S_IDLE.
- Bytes received while in S_BUS or S_RESP are discarded; the RX engine keeps running.
- Address alignment is not checked; mem_addr_o is driven verbatim.

TX byte engine:
- Sends start(0), 8 data bits LSB first, then stop(1), each exactly CLK_DIV cycles.
- Consecutive response bytes are sent back-to-back with no extra idle between them.
- tx_pin=1 whenever idle.

busy_o:
- Rises the cycle after a valid command byte is accepted in S_IDLE (NAK case included).
- Falls on the cycle of return to S_IDLE.

Test Plan:
- Write: send 57 00 10 00 00 EF BE AD DE; grant after 3 cycles -> exactly one request with we=1, addr=0x00001000, data=0xDEADBEEF, sel=F; then TX byte 0x06; busy_o low afterwards.
- Read: send 52 04 00 00 20; bench returns 0x12345678 with the grant -> one request with we=0, addr=0x20000004; TX bytes 78 56 34 12 back-to-back, each 10*CLK_DIV cycles.
- Invalid command: byte 0x41 -> TX 0x15, no mem_req_o.
- Glitch: rx_pin low for CLK_DIV/4 cycles -> no byte, FSM stays idle. Framing error: byte 0x52 with stop bit 0 -> frame aborted, no response.
- Timeout: send 57 00 10, then silence for TIMEOUT_CYC+10 cycles -> no bus access and no TX. A following complete read frame executes correctly.
- Reset: assert rst during S_BUS with mem_gnt_i held low -> mem_req_o=0 and tx_pin=1 the next cycle; no response after release.
